// File: rtl/mem_byte_sequencer_pkg.sv
// Shared definitions for the byte-serial load/store sequencer:
// width codes, state encoding, request payload and decode helpers.
package mem_byte_sequencer_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = DATA_W / BYTE_W;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned F3_W      = 3;

    // RISC-V width codes (funct3)
    localparam logic [F3_W-1:0] F3_B  = 3'b000;
    localparam logic [F3_W-1:0] F3_H  = 3'b001;
    localparam logic [F3_W-1:0] F3_W_ = 3'b010;
    localparam logic [F3_W-1:0] F3_BU = 3'b100;
    localparam logic [F3_W-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        logic [F3_W-1:0]   funct3;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] store_data;
    } req_t;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic write, input logic [F3_W-1:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W_: f3_legal = 1'b1;
            F3_BU, F3_HU:      f3_legal = !write;
            default:           f3_legal = 1'b0;
        endcase
    endfunction

    // Index of the final byte (N-1) of a transfer.
    function automatic logic [CNT_W-1:0] last_idx(input logic [F3_W-1:0] funct3);
        case (funct3)
            F3_H, F3_HU: last_idx = CNT_W'(1);
            F3_W_:       last_idx = CNT_W'(3);
            default:     last_idx = CNT_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// Request/response and byte-memory bus of the sequencer.
// master: requester + memory side; slave: the sequencer itself.
interface mem_byte_sequencer_if;
    import mem_byte_sequencer_pkg::*;

    logic              start;
    logic              write;
    logic [F3_W-1:0]   funct3;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] store_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W-1:0] mem_address;
    logic [BYTE_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [BYTE_W-1:0] mem_read_data;

    modport master (
        output start, write, funct3, address, store_data, mem_read_data,
        input  busy, done, error, load_data, mem_address, mem_write_data, mem_write_enable
    );

    modport slave (
        input  start, write, funct3, address, store_data, mem_read_data,
        output busy, done, error, load_data, mem_address, mem_write_data, mem_write_enable
    );

endinterface

// File: rtl/mem_byte_sequencer_load_extender.sv
// Combinational sign/zero extension of an assembled load word.
// Ports: raw_data (assembled bytes), funct3 (width code), result_c (extended value).
module load_extender
    import mem_byte_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] raw_data,
    input  logic [F3_W-1:0]   funct3,
    output logic [DATA_W-1:0] result_c
);

    always_comb begin
        result_c = '0;
        case (funct3)
            F3_B:    result_c = {{(DATA_W-8){raw_data[7]}}, raw_data[7:0]};
            F3_H:    result_c = {{(DATA_W-16){raw_data[15]}}, raw_data[15:0]};
            F3_BU:   result_c = DATA_W'(raw_data[7:0]);
            F3_HU:   result_c = DATA_W'(raw_data[15:0]);
            F3_W_:   result_c = raw_data;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Byte-serial load/store sequencer for a byte-wide memory.
// Ports: clk, reset (sync, active-high), bus (slave side of
// mem_byte_sequencer_if: request, response and memory byte port).
// All bus outputs are registered; next values derive from the next state.
module mem_byte_sequencer
    import mem_byte_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mem_byte_sequencer_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] ext_data;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [BYTE_W-1:0] mem_write_data_q, mem_write_data_d;
    logic              mem_write_enable_q, mem_write_enable_d;

    // Load assembly: merge the byte returned for the current cycle
    always_comb begin
        asm_d = asm_q;
        if (state_q == ST_XFER && !req_q.write) begin
            for (int i = 0; i < int'(NUM_BYTES); i++) begin
                if (CNT_W'(i) == cnt_q) asm_d[i*BYTE_W +: BYTE_W] = bus.mem_read_data;
            end
        end
    end

    load_extender u_load_extender (
        .raw_data (asm_d),
        .funct3   (req_q.funct3),
        .result_c (ext_data)
    );

    // Next state and next registered outputs
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        req_d              = req_q;
        load_data_d        = load_data_q;
        busy_d             = 1'b0;
        done_d             = 1'b0;
        error_d            = 1'b0;
        mem_address_d      = '0;
        mem_write_data_d   = '0;
        mem_write_enable_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    req_d.write      = bus.write;
                    req_d.funct3     = bus.funct3;
                    req_d.address    = bus.address;
                    req_d.store_data = bus.store_data;
                    cnt_d            = '0;
                    if (f3_legal(bus.write, bus.funct3)) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d     = ST_DONE;
                        error_d     = 1'b1;
                        load_data_d = '0;
                    end
                end
            end
            ST_XFER: begin
                if (cnt_q == last_idx(req_q.funct3)) begin
                    state_d = ST_DONE;
                    if (!req_q.write) load_data_d = ext_data;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);

        // Address wraps naturally modulo 2^32
        if (state_d == ST_XFER) begin
            mem_address_d = req_d.address + ADDR_W'(cnt_d);
            if (req_d.write) begin
                mem_write_enable_d = 1'b1;
                for (int i = 0; i < int'(NUM_BYTES); i++) begin
                    if (CNT_W'(i) == cnt_d) mem_write_data_d = req_d.store_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            cnt_q              <= '0;
            req_q              <= '0;
            asm_q              <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            load_data_q        <= '0;
            mem_address_q      <= '0;
            mem_write_data_q   <= '0;
            mem_write_enable_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            req_q              <= req_d;
            asm_q              <= asm_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            error_q            <= error_d;
            load_data_q        <= load_data_d;
            mem_address_q      <= mem_address_d;
            mem_write_data_q   <= mem_write_data_d;
            mem_write_enable_q <= mem_write_enable_d;
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.error            = error_q;
    assign bus.load_data        = load_data_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_write_enable = mem_write_enable_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Self-checking bench for mem_byte_sequencer: directed scenarios plus
// randomized requests against a byte-array reference model.
module tb_mem_byte_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   mem_gen;

    mem_byte_sequencer_if bif ();

    mem_byte_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical byte memory written only by the DUT
    logic [7:0] phys_mem [logic [31:0]];
    // Reference memory maintained by the model
    logic [7:0] ref_mem [logic [31:0]];
    logic [31:0] exp_load;

    function automatic logic [7:0] phys_rd(input logic [31:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (bif.mem_write_enable === 1'b1) begin
            phys_mem[bif.mem_address] = bif.mem_write_data;
            mem_gen = mem_gen + 1;
        end
    end

    always @(bif.mem_address or mem_gen) bif.mem_read_data = phys_rd(bif.mem_address);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int width_of(input logic [2:0] f3);
        if (f3 == 3'b010) return 4;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 1;
    endfunction

    function automatic logic is_legal(input logic w, input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) return 1'b1;
        if (f3 == 3'b100 || f3 == 3'b101) return !w;
        return 1'b0;
    endfunction

    // Expected load value from the reference memory
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] raw;
        raw = 32'h0;
        for (int k = 0; k < width_of(f3); k++) raw = raw | (32'(ref_rd(a + 32'(k))) << (8 * k));
        case (f3)
            3'b000:  return 32'($signed(raw[7:0]));
            3'b001:  return 32'($signed(raw[15:0]));
            3'b100:  return 32'(raw[7:0]);
            3'b101:  return 32'(raw[15:0]);
            default: return raw;
        endcase
    endfunction

    task automatic idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(bif.busy), 32'd0);
        check({tag, "_done"}, 32'(bif.done), 32'd0);
        check({tag, "_we"},   32'(bif.mem_write_enable), 32'd0);
        check({tag, "_addr"}, bif.mem_address, 32'h0);
    endtask

    // One full request; inputs are scrambled after the start edge
    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        int n;
        n = width_of(f3);
        @(negedge clk);
        bif.start = 1'b1; bif.write = w; bif.funct3 = f3; bif.address = a; bif.store_data = d;
        @(negedge clk);
        bif.start      = 1'b0;
        bif.write      = 1'($urandom_range(0, 1));
        bif.funct3     = 3'($urandom_range(0, 7));
        bif.address    = $urandom;
        bif.store_data = $urandom;
        if (!is_legal(w, f3)) begin
            exp_load = 32'h0;
            check({tag, "_ill_done"},  32'(bif.done), 32'd1);
            check({tag, "_ill_error"}, 32'(bif.error), 32'd1);
            check({tag, "_ill_we"},    32'(bif.mem_write_enable), 32'd0);
            check({tag, "_ill_load"},  bif.load_data, exp_load);
        end else begin
            for (int k = 0; k < n; k++) begin
                check({tag, "_x_busy"}, 32'(bif.busy), 32'd1);
                check({tag, "_x_done"}, 32'(bif.done), 32'd0);
                check({tag, "_x_addr"}, bif.mem_address, a + 32'(k));
                check({tag, "_x_we"},   32'(bif.mem_write_enable), 32'(w));
                if (w) begin
                    check({tag, "_x_wdata"}, 32'(bif.mem_write_data), (d >> (8 * k)) & 32'hFF);
                    ref_mem[a + 32'(k)] = 8'((d >> (8 * k)) & 32'hFF);
                end
                @(negedge clk);
            end
            if (!w) exp_load = model_load(f3, a);
            check({tag, "_d_done"},  32'(bif.done), 32'd1);
            check({tag, "_d_busy"},  32'(bif.busy), 32'd1);
            check({tag, "_d_error"}, 32'(bif.error), 32'd0);
            check({tag, "_d_we"},    32'(bif.mem_write_enable), 32'd0);
            check({tag, "_d_addr"},  bif.mem_address, 32'h0);
            check({tag, "_d_load"},  bif.load_data, exp_load);
        end
        @(negedge clk);
        idle_outputs({tag, "_idle"});
        check({tag, "_idle_load"}, bif.load_data, exp_load);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        w;
        n_checks = 0; n_pass = 0; mem_gen = 0; exp_load = 32'h0;
        reset = 1'b1;
        bif.start = 1'b0; bif.write = 1'b0; bif.funct3 = 3'b0;
        bif.address = 32'h0; bif.store_data = 32'h0;
        repeat (2) @(negedge clk);
        idle_outputs("reset");
        check("reset_error", 32'(bif.error), 32'd0);
        check("reset_load",  bif.load_data, 32'h0);
        check("reset_wdata", 32'(bif.mem_write_data), 32'h0);

        // Reset wins over a simultaneous start
        bif.start = 1'b1; bif.write = 1'b1; bif.funct3 = 3'b010; bif.address = 32'h3000;
        @(negedge clk);
        idle_outputs("rst_prio");
        bif.start = 1'b0; reset = 1'b0;
        @(negedge clk);
        idle_outputs("rst_release");

        // Directed scenarios
        do_req("sw",   1'b1, 3'b010, 32'h1000, 32'h11223344);
        do_req("lw",   1'b0, 3'b010, 32'h1000, 32'h0);
        check("lw_const", bif.load_data, 32'h11223344);
        do_req("sb",   1'b1, 3'b000, 32'h1005, 32'h5A5A5A80);
        do_req("lb",   1'b0, 3'b000, 32'h1005, 32'h0);
        check("lb_const", bif.load_data, 32'hFFFFFF80);
        do_req("lbu",  1'b0, 3'b100, 32'h1005, 32'h0);
        check("lbu_const", bif.load_data, 32'h00000080);
        do_req("lh",   1'b0, 3'b001, 32'h1004, 32'h0);
        check("lh_const", bif.load_data, 32'hFFFF8000);
        do_req("lhwrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
        do_req("ill011", 1'b0, 3'b011, 32'h1000, 32'h0);
        check("ill_const", bif.load_data, 32'h0);
        do_req("sbu",  1'b1, 3'b100, 32'h1000, 32'hDEADBEEF);
        do_req("lw2",  1'b0, 3'b010, 32'h1000, 32'h0);
        check("sbu_no_write", bif.load_data, 32'h11223344);

        // start held high: one LW every N+2 = 6 cycles
        @(negedge clk);
        bif.start = 1'b1; bif.write = 1'b0; bif.funct3 = 3'b010; bif.address = 32'h1000;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            check("hold_done", 32'(bif.done), 32'((e % 6) == 5));
            check("hold_busy", 32'(bif.busy), 32'((e % 6) != 0));
        end
        bif.start = 1'b0;
        exp_load = model_load(3'b010, 32'h1000);
        @(negedge clk);
        idle_outputs("hold_end");
        check("hold_load", bif.load_data, exp_load);

        // Reset abort of SW 0xAABBCCDD at 0x1010 after its first byte
        @(negedge clk);
        bif.start = 1'b1; bif.write = 1'b1; bif.funct3 = 3'b010;
        bif.address = 32'h1010; bif.store_data = 32'hAABBCCDD;
        @(negedge clk);
        bif.start = 1'b0;
        check("abort_addr0", bif.mem_address, 32'h1010);
        check("abort_we0",   32'(bif.mem_write_enable), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_outputs("abort_rst");
        exp_load = 32'h0;
        ref_mem[32'h1010] = 8'hDD;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bif.done), 32'd0);
            check("abort_no_we",   32'(bif.mem_write_enable), 32'd0);
        end
        check("abort_mem1010", 32'(phys_rd(32'h1010)), 32'hDD);
        check("abort_mem1011", 32'(phys_rd(32'h1011)), 32'h00);
        do_req("abort_lw", 1'b0, 3'b010, 32'h1010, 32'h0);

        // Randomized requests
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h2000 + 32'($urandom_range(0, 15));
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            do_req("rand", w, f3, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_byte_sequencer.md
MEM_BYTE_SEQUENCER -- requirements
Module: mem_byte_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-002 The module SHALL have the following ports:
- start  input  1  request strobe, sampled only in IDLE
- write  input  1  1=store, 0=load
- funct3  input  3  RISC-V width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- address  input  32  byte address of the first (least-significant) byte
- store_data  input  32  store operand; low N bytes are used
- busy  output  1  high while a request is in progress
- done  output  1  one-cycle completion pulse
- error  output  1  one-cycle pulse, coincident with done, for an illegal funct3
- load_data  output  32  extended load result; held until the next done
- mem_address  output  32  byte address to the byte-wide memory
- mem_write_data  output  8  byte to store
- mem_write_enable  output  1  byte write strobe; the memory commits it on clk
- mem_read_data  input  8  combinational read byte from the memory

Function
REQ-003 States SHALL be IDLE, XFER and DONE.
REQ-004 IDLE: start=1 at a clock edge SHALL latch write, funct3, address and store_data, and move to XFER with byte counter=0; start=0 SHALL remain in IDLE.
REQ-005 N SHALL be 1 for funct3 000/100, 2 for 001/101, and 4 for 010.
REQ-006 Illegal funct3 (011, 110, 111 for all requests; 100 and 101 for stores) SHALL go IDLE->DONE directly, assert error together with done, issue no memory access, and set load_data=0.
REQ-007 In XFER, cycle k (k=0..N-1) SHALL drive mem_address=latched address+k, computed modulo 2^32 so that 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-008 Stores: each XFER cycle k SHALL drive mem_write_data=store_data[8k+7:8k] with mem_write_enable=1 (little-endian).
REQ-009 Loads: at the end of XFER cycle k, mem_read_data SHALL be captured into byte k of an assembly register; mem_write_enable SHALL stay 0.
REQ-010 After cycle N-1 the state SHALL go to DONE, which lasts exactly one cycle with done=1, then returns to IDLE.
REQ-011 load_data SHALL update on the XFER->DONE transition as follows:
- LB: sign-extend bit 7
- LH: sign-extend bit 15
- LBU/LHU: zero-extend
- LW: pass through
- stores: load_data is unchanged
REQ-012 Latency from the start edge to done SHALL be N+1 cycles; a new start is accepted at the earliest in the cycle after DONE.
REQ-013 busy SHALL be 1 in XFER and DONE and 0 in IDLE; start while busy SHALL be ignored and not queued.
REQ-014 In IDLE and DONE, mem_address SHALL be 0, mem_write_data 0 and mem_write_enable 0.
REQ-015 Input changes after the start edge SHALL NOT affect the request in progress.

Reset
REQ-016 reset=1 at a clock edge SHALL force IDLE, counter=0, busy=0, done=0, error=0, load_data=0 and all mem_* outputs=0.
REQ-017 Reset during XFER SHALL abort the request: no further writes, no done pulse; bytes already written remain in memory.
REQ-018 Reset SHALL take priority over start in the same cycle.

Structure
REQ-019 The funct3 width codes and state encodings SHALL be defined in the shared arch_defines.v, not locally.
REQ-020 Sign/zero extension SHALL be a combinational sub-module, load_extender (inputs: 32-bit raw data and funct3; output: 32-bit result).
REQ-021 The memory port SHALL connect directly to memory_synth-style byte memory ports (address, write_data, write_enable, read_data, clk) with no extra glue.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- SW 0x11223344 at 0x1000, then LW at 0x1000: writes 44,33,22,11 on cycles 1-4; done at cycle 5; load_data=0x11223344.
- SB 0x80 at 0x1005, then LB 0x1005 -> 0xFFFFFF80; LBU 0x1005 -> 0x00000080; LH 0x1004 with 0x1004=0x00 -> 0xFFFF8000.
- LH at 0xFFFFFFFF: mem_address sequence 0xFFFFFFFF then 0x00000000; done after 3 cycles.
- funct3=011 load: done and error high the cycle after start; mem_write_enable never 1; load_data=0.
- Reset in the 2nd XFER cycle of SW 0xAABBCCDD at 0x1010: only 0x1010=0xDD is written; no done; busy=0 next cycle.
- start held high continuously: one request per N+2 cycles, and start during busy is ignored.
